// File: rtl/counter_rr_scheduler_pkg.sv
// Shared types and the round-robin search used by the counter scheduler.
// Pure combinational helpers; no state lives here.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Search vector is sized for the largest supported NREQ; callers zero-extend.
  localparam int RR_VEC_W = 16;
  localparam int RR_ID_W  = 4;

  typedef struct packed {
    logic               found;
    logic [RR_ID_W-1:0] id;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [RR_VEC_W-1:0] req,
                                       input logic [RR_ID_W-1:0]  last,
                                       input int                  n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = 1; i <= RR_VEC_W; i++) begin
      idx = (int'(last) + i) % n;
      if (i <= n && !r.found && req[idx]) begin
        r.found = 1'b1;
        r.id    = RR_ID_W'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_rr_scheduler_if.sv
// Request/accept and completion signals between clients and the counter scheduler.
// Accept is a valid/ready handshake; completion is an unqualified one-cycle pulse.
interface counter_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_len;
  logic [NREQ-1:0]   req_ready;
  logic              abort;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic [W-1:0]      cnt_out;
  logic              done_valid;
  logic [IDW-1:0]    done_id;
  logic              done_aborted;

  modport master (
    output req_valid, req_len, abort,
    input  req_ready, busy, grant_id, cnt_out, done_valid, done_id, done_aborted
  );

  modport slave (
    input  req_valid, req_len, abort,
    output req_ready, busy, grant_id, cnt_out, done_valid, done_id, done_aborted
  );
endinterface

// File: rtl/counter_rr_scheduler_tick_counter.sv
// W-bit up-counter with synchronous clear taking priority over enable.
// Value visible one cycle after clr/en; no backpressure.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rstn)    q_q <= '0;
    else if (clr) q_q <= '0;
    else if (en)  q_q <= q_q + W'(1);
  end

  assign q = q_q;
endmodule

// File: rtl/counter_rr_scheduler.sv
// Round-robin owner of one shared tick counter; accept is combinational in IDLE,
// run of L ticks completes with a done pulse L+1 cycles after accept, no accept while busy.
module counter_rr_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input logic                   clk,
  input logic                   rstn,
  counter_rr_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  sched_state_e   state_q, state_d;
  logic [W-1:0]   len_q, len_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic           aborted_q, aborted_d;

  rr_pick_t       pick;
  logic           any_req;
  logic [IDW-1:0] sel;
  logic [W-1:0]   sel_len;
  logic [W-1:0]   cnt_q;
  logic           last_tick;
  logic           cnt_clr;
  logic           cnt_en;
  logic           accept;

  always_comb begin
    pick    = rr_pick(RR_VEC_W'(bus.req_valid), RR_ID_W'(last_q), NREQ);
    any_req = pick.found;
    sel     = pick.id[IDW-1:0];
    sel_len = bus.req_len[int'(sel)*W +: W];
  end

  assign last_tick = (cnt_q == len_q - W'(1));
  assign accept    = (state_q == IDLE) && any_req;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      grant_q   <= '0;
      last_q    <= IDW'(NREQ - 1);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = (sel_len == '0) ? DONE : RUN;
      RUN:     if (last_tick || bus.abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort only wins when it arrives before the final tick.
  always_comb begin
    len_d     = len_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aborted_d = aborted_q;
    if (accept) begin
      len_d     = sel_len;
      grant_d   = sel;
      last_d    = sel;
      aborted_d = 1'b0;
    end else if (state_q == RUN && bus.abort && !last_tick) begin
      aborted_d = 1'b1;
    end
  end

  always_comb begin
    bus.req_ready = accept ? (NREQ'(1) << sel) : '0;
    bus.busy      = (state_q != IDLE);
    bus.done_valid = (state_q == DONE);
    cnt_clr       = accept;
    cnt_en        = (state_q == RUN) && (last_tick || !bus.abort);
  end

  tick_counter #(.W(W)) u_tick_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .q    (cnt_q)
  );

  assign bus.grant_id     = grant_q;
  assign bus.cnt_out      = cnt_q;
  assign bus.done_id      = grant_q;
  assign bus.done_aborted = aborted_q;
endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler (NREQ=4, W=8).
module tb_counter_rr_scheduler;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  counter_rr_scheduler_if #(.NREQ(4), .W(8)) bus ();

  counter_rr_scheduler #(.NREQ(4), .W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (bus.busy === 1'b1 && c < 400) begin
      step();
      c++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout: busy got %0b required 0", name, bus.busy);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.abort     = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0000", bus.req_ready); end
    n_cmp++; if (bus.cnt_out !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d required 0", bus.cnt_out); end
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d required 0", bus.grant_id); end
    n_cmp++; if ({bus.done_valid, bus.done_id, bus.done_aborted} !== 4'b0) begin
      n_err++; $display("FAIL reset_done: got v=%0b id=%0d ab=%0b required 0/0/0", bus.done_valid, bus.done_id, bus.done_aborted);
    end
  endtask

  task automatic test_single();
    int bad;
    bus.req_valid = 4'b0001;
    bus.req_len[0 +: 8] = 8'd5;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b required 0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      if (bus.cnt_out !== 8'(k - 1) || bus.busy !== 1'b1 || bus.done_valid !== 1'b0 || bus.grant_id !== 2'd0) bad++;
      step();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL single_run: got %0d bad RUN cycles required 0", bad); end
    n_cmp++; if (bus.done_valid !== 1'b1 || bus.done_id !== 2'd0 || bus.done_aborted !== 1'b0) begin
      n_err++; $display("FAIL single_done: got v=%0b id=%0d ab=%0b required 1/0/0", bus.done_valid, bus.done_id, bus.done_aborted);
    end
    n_cmp++; if (bus.cnt_out !== 8'd5) begin n_err++; $display("FAIL single_final_cnt: got %0d required 5", bus.cnt_out); end
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.done_valid !== 1'b0 || bus.cnt_out !== 8'd5) begin
      n_err++; $display("FAIL single_idle: got busy=%0b v=%0b cnt=%0d required 0/0/5", bus.busy, bus.done_valid, bus.cnt_out);
    end
  endtask

  task automatic test_round_robin();
    int order [5];
    int g, d, prev;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_len[i*8 +: 8] = 8'd2;
    g = 0; d = 0; prev = -4;
    for (int c = 0; c < 19; c++) begin
      #1;
      if (bus.req_ready !== 4'b0) begin
        n_cmp++;
        if (g >= 5 || bus.req_ready !== (4'b0001 << order[g]) || c - prev != 4) begin
          n_err++; $display("FAIL rr_accept%0d: got ready=%b gap=%0d required ready=%b gap=4", g, bus.req_ready, c - prev, 4'b0001 << order[g % 5]);
        end
        prev = c;
        g++;
      end
      if (bus.done_valid === 1'b1 && d < 4) begin
        n_cmp++;
        if (bus.done_id !== 2'(order[d])) begin n_err++; $display("FAIL rr_done%0d: got id=%0d required %0d", d, bus.done_id, order[d]); end
        d++;
      end
      step();
    end
    n_cmp++; if (g != 5) begin n_err++; $display("FAIL rr_count: got %0d accepts required 5", g); end
    bus.req_valid = '0;
    wait_idle("rr");
  endtask

  task automatic test_zero_len();
    bus.req_valid = 4'b0100;
    bus.req_len[16 +: 8] = 8'd0;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL zero_ready: got %b required 0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    n_cmp++; if (bus.done_valid !== 1'b1 || bus.done_id !== 2'd2 || bus.cnt_out !== 8'd0 || bus.done_aborted !== 1'b0) begin
      n_err++; $display("FAIL zero_done: got v=%0b id=%0d cnt=%0d ab=%0b required 1/2/0/0", bus.done_valid, bus.done_id, bus.cnt_out, bus.done_aborted);
    end
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.done_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_after: got busy=%0b v=%0b required 0/0", bus.busy, bus.done_valid);
    end
  endtask

  task automatic test_abort_early();
    bus.req_valid = 4'b0010;
    bus.req_len[8 +: 8] = 8'd10;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL abort_early_ready: got %b required 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    step(); step(); step();
    bus.abort = 1'b1;
    #1;
    n_cmp++; if (bus.cnt_out !== 8'd3) begin n_err++; $display("FAIL abort_early_run4: got %0d required 3", bus.cnt_out); end
    step();
    bus.abort = 1'b0;
    n_cmp++; if (bus.done_valid !== 1'b1 || bus.done_aborted !== 1'b1 || bus.done_id !== 2'd1 || bus.cnt_out !== 8'd3) begin
      n_err++; $display("FAIL abort_early_done: got v=%0b ab=%0b id=%0d cnt=%0d required 1/1/1/3", bus.done_valid, bus.done_aborted, bus.done_id, bus.cnt_out);
    end
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.cnt_out !== 8'd3) begin
      n_err++; $display("FAIL abort_early_hold: got busy=%0b cnt=%0d required 0/3", bus.busy, bus.cnt_out);
    end
  endtask

  task automatic test_abort_last();
    bus.req_valid = 4'b1000;
    bus.req_len[24 +: 8] = 8'd10;
    step();
    bus.req_valid = '0;
    for (int k = 0; k < 9; k++) step();
    n_cmp++; if (bus.cnt_out !== 8'd9 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL abort_last_run10: got cnt=%0d busy=%0b required 9/1", bus.cnt_out, bus.busy);
    end
    bus.abort = 1'b1;
    step();
    n_cmp++; if (bus.done_valid !== 1'b1 || bus.done_aborted !== 1'b0 || bus.done_id !== 2'd3 || bus.cnt_out !== 8'd10) begin
      n_err++; $display("FAIL abort_last_done: got v=%0b ab=%0b id=%0d cnt=%0d required 1/0/3/10", bus.done_valid, bus.done_aborted, bus.done_id, bus.cnt_out);
    end
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.cnt_out !== 8'd10 || bus.done_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_idle_ignored: got busy=%0b cnt=%0d v=%0b required 0/10/0", bus.busy, bus.cnt_out, bus.done_valid);
    end
    bus.abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bus.req_valid = 4'b0100;
    bus.req_len[16 +: 8] = 8'd200;
    step();
    bus.req_valid = '0;
    for (int k = 0; k < 49; k++) step();
    n_cmp++; if (bus.cnt_out !== 8'd49) begin n_err++; $display("FAIL rstmid_run50: got %0d required 49", bus.cnt_out); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.cnt_out !== 8'd0 || bus.grant_id !== 2'd0 || bus.done_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state: got busy=%0b cnt=%0d gid=%0d v=%0b required 0/0/0/0", bus.busy, bus.cnt_out, bus.grant_id, bus.done_valid);
    end
    step();
    n_cmp++; if (bus.done_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got %0b required 0", bus.done_valid); end
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_len[i*8 +: 8] = 8'd1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_priority: got %b required 0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    wait_idle("rstmid");
  endtask

  task automatic test_max_len();
    int bad;
    bus.req_valid = 4'b0010;
    bus.req_len[8 +: 8] = 8'd255;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL max_ready: got %b required 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    bad = 0;
    for (int k = 1; k <= 255; k++) begin
      if (bus.cnt_out !== 8'(k - 1) || bus.busy !== 1'b1 || bus.done_valid !== 1'b0) bad++;
      step();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL max_run: got %0d bad RUN cycles required 0", bad); end
    n_cmp++; if (bus.done_valid !== 1'b1 || bus.cnt_out !== 8'd255 || bus.done_id !== 2'd1) begin
      n_err++; $display("FAIL max_done: got v=%0b cnt=%0d id=%0d required 1/255/1", bus.done_valid, bus.cnt_out, bus.done_id);
    end
    step();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.abort     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_abort_early();
    test_abort_last();
    test_reset_mid_run();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
